ddr_wr_burst_ctrl: RTL and testbench

- Drains the 256-bit read side of the camera write FIFO (32-bit in, 256-bit out, 256-deep read side) into DDR write bursts.
- Waits for the FIFO read water level to reach one burst, then issues a burst command. It pops exactly BURST_LEN words and streams them to the DDR write-data channel.
- Advances a linear frame address and wraps it at the frame boundary.
- Sits between the write FIFO and the DDR controller write port, one instance per video channel.

---
 rtl/ddr_wr_burst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ddr_wr_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the 256-bit read side of the camera write FIFO into DDR write bursts with a wrapping frame address.
// Optional watchdog: define DDR_WR_BURST_CTRL_TIMEOUT_EN to build the sticky timeout_err logic.
module ddr_wr_burst_ctrl #(
    parameter int RD_DEPTH_WIDTH = 8,
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 28,
    parameter int BURST_LEN      = 16,
    parameter int FRAME_BASE     = 0,
    parameter int FRAME_BEATS    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    tb_rst,
    input  logic                    frame_start,
    input  logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [ADDR_WIDTH-1:0]   cmd_addr,
    output logic [7:0]              cmd_len,
    output logic                    wdata_valid,
    input  logic                    wdata_ready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    wdata_last,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    localparam int                    BCW         = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [RD_DEPTH_WIDTH:0] LVL_NEED  = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > 2**RD_DEPTH_WIDTH || (FRAME_BEATS % BURST_LEN) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("ddr_wr_burst_ctrl: illegal parameter combination");
    end

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             frame_cnt_q;
    logic                    pend_q;
    logic                    frame_done_q;
    logic [BCW-1:0]          pop_cnt_q;
    logic [BCW-1:0]          beat_cnt_q;
    logic                    rd_inflight_q;
    logic [1:0]              skid_cnt_q;
    logic [DATA_WIDTH-1:0]   skid_q [2];

    logic                    in_data, cmd_acc, skid_pop, last_acc, wr_idx;
    logic [1:0]              occ;

    assign in_data  = (state_q == DATA);
    assign cmd_acc  = (state_q == CMD) && cmd_ready;
    assign skid_pop = in_data && (skid_cnt_q != 2'd0) && wdata_ready;
    assign last_acc = skid_pop && (beat_cnt_q == BCW'(BURST_LEN - 1));
    // Slots committed after this cycle: held beats, plus the read landing next cycle, minus the beat leaving now.
    assign occ      = skid_cnt_q + {1'b0, rd_inflight_q} - {1'b0, skid_pop};
    assign wr_idx   = ((skid_cnt_q - {1'b0, skid_pop}) == 2'd1);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_rd_water_level >= LVL_NEED) state_d = CMD;
            CMD:     if (cmd_ready) state_d = DATA;
            DATA:    if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid   = (state_q == CMD);
        cmd_addr    = cmd_valid ? addr_q : '0;
        cmd_len     = cmd_valid ? 8'(BURST_LEN - 1) : 8'd0;
        wdata_valid = in_data && (skid_cnt_q != 2'd0);
        wdata       = wdata_valid ? skid_q[0] : '0;
        wdata_last  = wdata_valid && (beat_cnt_q == BCW'(BURST_LEN - 1));
        busy        = (state_q != IDLE);
        frame_done  = frame_done_q;
        // The first pop is issued on command acceptance so beats start two cycles later.
        fifo_rd_en  = (in_data || cmd_acc) && (pop_cnt_q != BCW'(BURST_LEN)) && (occ < 2'd2);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            pop_cnt_q     <= '0;
            beat_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            skid_cnt_q    <= 2'd0;
        end else begin
            rd_inflight_q <= fifo_rd_en;
            skid_cnt_q    <= skid_cnt_q + {1'b0, rd_inflight_q} - {1'b0, skid_pop};
            if (last_acc)        pop_cnt_q <= '0;
            else if (fifo_rd_en) pop_cnt_q <= pop_cnt_q + 1'b1;
            if (last_acc)        beat_cnt_q <= '0;
            else if (skid_pop)   beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    // NOTE: the skid data array is not reset; wdata is masked by wdata_valid so stale contents never escape.
    always_ff @(posedge clk) begin
        if (skid_pop)      skid_q[0]      <= skid_q[1];
        if (rd_inflight_q) skid_q[wr_idx] <= fifo_rd_data;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            addr_q       <= BASE_ADDR;
            frame_cnt_q  <= '0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_start)          pend_q <= 1'b1;
            else if (state_q == IDLE) pend_q <= 1'b0;

            // A restart only lands in IDLE, so a burst in flight always finishes at its own address.
            if (state_q == IDLE && pend_q) begin
                addr_q      <= BASE_ADDR;
                frame_cnt_q <= '0;
            end else if (last_acc) begin
                if (frame_cnt_q + 32'(BURST_LEN) == 32'(FRAME_BEATS)) begin
                    addr_q       <= BASE_ADDR;
                    frame_cnt_q  <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    addr_q      <= addr_q + BURST_BYTES;
                    frame_cnt_q <= frame_cnt_q + 32'(BURST_LEN);
                end
            end
        end
    end

`ifdef DDR_WR_BURST_CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt_q;
    logic [15:0] wd_next;
    logic        timeout_q;

    assign wd_next     = wd_cnt_q + 16'd1;
    assign timeout_err = timeout_q;

    // Counts consecutive handshake-free cycles while a burst is outstanding; saturates at all-ones.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == IDLE || cmd_acc || skid_pop) begin
            wd_cnt_q  <= '0;
        end else begin
            if (wd_cnt_q != 16'hFFFF) wd_cnt_q <= wd_next;
            if (wd_next == 16'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Scoreboard bench for ddr_wr_burst_ctrl: stimulus queues expected commands/beats, a negedge monitor checks them.
module tb_ddr_wr_burst_ctrl;

    localparam int DW  = 256;
    localparam int AW  = 28;
    localparam int BL  = 16;
    localparam int TMO = 100;
`ifdef DDR_WR_BURST_CTRL_TIMEOUT_EN
    localparam logic EXP_TMO = 1'b1;
`else
    localparam logic EXP_TMO = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          tb_rst;
    logic          frame_start;
    logic [8:0]    fifo_rd_water_level;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic          wdata_last;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    ddr_wr_burst_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .tb_rst(tb_rst), .frame_start(frame_start),
        .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_last(wdata_last),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int            n_pass = 0;
    int            n_total = 0;
    int            burst_pops = 0;
    int            underflows = 0;
    int            done_cnt = 0;
    int            seq = 0;
    logic          bp_en = 1'b0;
    logic          stall_pending = 1'b0;
    logic [DW-1:0] stall_data;
    logic [DW-1:0] fifo_nxt;
    logic [DW-1:0] fifo_q [$];
    logic [AW-1:0] exp_cmd_q [$];
    beat_t         exp_beat_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queues one burst worth of FIFO words plus the command and beats the DUT must produce for it.
    task automatic push_burst(input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        exp_cmd_q.push_back(addr);
        for (int i = 0; i < BL; i++) begin
            for (int l = 0; l < DW / 32; l++) w[l*32 +: 32] = 32'(seq * 8 + l) ^ 32'h5A00_0000;
            seq++;
            fifo_q.push_back(w);
            exp_beat_q.push_back('{data: w, last: (i == BL - 1)});
        end
    endtask

    task automatic wait_burst(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 300)  begin @(negedge clk); n++; end
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        check(name, busy === 1'b0, 1'b1);
        tick();
    endtask

    task automatic wait_beat(input string name);
        int n = 0;
        while (wdata_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check(name, wdata_valid, 1'b1);
    endtask

    task automatic run_burst(input logic [AW-1:0] addr);
        burst_pops = 0;
        push_burst(addr);
        wait_burst("burst_complete");
        check("pops_per_burst", 32'(burst_pops), 32'(BL));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_cmd_addr"}, cmd_addr, '0);
        check({tag, "_cmd_len"}, cmd_len, '0);
        check({tag, "_wdata_valid"}, wdata_valid, 1'b0);
        check({tag, "_wdata"}, wdata, '0);
        check({tag, "_wdata_last"}, wdata_last, 1'b0);
        check({tag, "_fifo_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // FIFO model: a pop seen in a cycle presents its word on fifo_rd_data in the next cycle.
    always begin
        @(negedge clk);
        if (fifo_rd_en === 1'b1 && tb_rst === 1'b0) begin
            burst_pops++;
            if (fifo_q.size() == 0) begin
                underflows++;
                fifo_nxt = '0;
            end else begin
                fifo_nxt = fifo_q.pop_front();
            end
            @(posedge clk);
            #1 fifo_rd_data = fifo_nxt;
        end
    end

    always @(posedge clk) begin
        #2 fifo_rd_water_level = 9'(fifo_q.size());
    end

    always @(posedge clk) begin
        #1 if (bp_en) wdata_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshakes are sampled mid-cycle and complete at the following rising edge.
    always @(negedge clk) begin
        if (tb_rst === 1'b1) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid_held", wdata_valid, 1'b1);
                check("stall_data_held", wdata, stall_data);
            end
            if (cmd_valid && cmd_ready) begin
                check("cmd_expected", exp_cmd_q.size() != 0, 1'b1);
                if (exp_cmd_q.size() != 0) check("cmd_addr", cmd_addr, exp_cmd_q.pop_front());
                check("cmd_len", cmd_len, 8'h0F);
            end
            if (wdata_valid && wdata_ready) begin
                beat_t b;
                check("beat_expected", exp_beat_q.size() != 0, 1'b1);
                if (exp_beat_q.size() != 0) begin
                    b = exp_beat_q.pop_front();
                    check("wdata", wdata, b.data);
                    check("wdata_last", wdata_last, b.last);
                end
            end
            stall_pending = wdata_valid && !wdata_ready;
            stall_data    = wdata;
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        int streamed;
        tb_rst = 1'b1;
        frame_start = 1'b0;
        cmd_ready = 1'b0;
        wdata_ready = 1'b0;
        fifo_rd_water_level = '0;
        fifo_rd_data = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        tick();
        tb_rst = 1'b0;
        repeat (9) tick();

        // Fill: level reaches one burst, command follows one cycle later and is held while stalled.
        burst_pops = 0;
        push_burst(28'h0000000);
        @(negedge clk);
        check("cmd_valid_before_level_seen", cmd_valid, 1'b0);
        @(negedge clk);
        check("cmd_valid_latency", cmd_valid, 1'b1);
        check("cmd_addr_first", cmd_addr, 28'h0000000);
        check("cmd_len_first", cmd_len, 8'h0F);
        repeat (3) @(negedge clk);
        check("cmd_valid_held", cmd_valid, 1'b1);
        check("busy_in_cmd", busy, 1'b1);

        // Full-rate burst: first beat two cycles after acceptance, then 16 back-to-back beats.
        tick();
        cmd_ready = 1'b1;
        wdata_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first_beat_not_early", wdata_valid, 1'b0);
        @(negedge clk);
        check("first_beat_latency", wdata_valid, 1'b1);
        streamed = int'(wdata_valid);
        repeat (BL - 1) begin
            @(negedge clk);
            streamed += int'(wdata_valid);
        end
        check("beats_back_to_back", 32'(streamed), 32'(BL));
        @(negedge clk);
        check("idle_after_burst", busy, 1'b0);
        check("pops_first_burst", 32'(burst_pops), 32'(BL));
        tick();
        run_burst(28'h0000200);

        // frame_start mid-burst: the burst at 0x400 completes there, the next one restarts at base.
        burst_pops = 0;
        push_burst(28'h0000400);
        wait_beat("restart_burst_started");
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_burst("restart_burst_complete");
        check("pops_restart_burst", 32'(burst_pops), 32'(BL));
        run_burst(28'h0000000);

        // Random write-data backpressure.
        bp_en = 1'b1;
        run_burst(28'h0000200);
        run_burst(28'h0000400);
        bp_en = 1'b0;
        tick();
        wdata_ready = 1'b1;

        // Remaining bursts of the frame; frame_done fires after the burst at 0x7E00.
        for (int k = 3; k < 64; k++) begin
            if (k == 63) check("no_frame_done_early", 32'(done_cnt), 32'd0);
            run_burst(AW'(k * 512));
        end
        check("frame_done_single_pulse", 32'(done_cnt), 32'd1);
        run_burst(28'h0000000);

        // Command stall for watchdog behaviour.
        cmd_ready = 1'b0;
        burst_pops = 0;
        push_burst(28'h0000200);
        begin
            int n = 0;
            while (cmd_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end
        check("stall_cmd_valid", cmd_valid, 1'b1);
        repeat (TMO - 1) @(negedge clk);
        check("timeout_not_early", timeout_err, 1'b0);
        @(negedge clk);
        check("timeout_rise", timeout_err, EXP_TMO);
        tick();
        cmd_ready = 1'b1;
        wait_burst("stall_burst_complete");
        check("timeout_sticky", timeout_err, EXP_TMO);
        check("pops_stall_burst", 32'(burst_pops), 32'(BL));

        // Reset in the middle of the data phase.
        burst_pops = 0;
        push_burst(28'h0000400);
        wait_beat("reset_burst_started");
        tick();
        tb_rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        fifo_q.delete();
        exp_cmd_q.delete();
        exp_beat_q.delete();
        tick();
        tb_rst = 1'b0;
        tick();
        run_burst(28'h0000000);

        check("scoreboard_cmds_drained", 32'(exp_cmd_q.size()), 32'd0);
        check("scoreboard_beats_drained", 32'(exp_beat_q.size()), 32'd0);
        check("fifo_never_underflowed", 32'(underflows), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
